// File: rtl/rps_move_capture.sv
`default_nettype none
// ============================================================================
//  Module   : rps_move_capture
//  Brief    : Rock/paper/scissors round front end. Countdown, capture window,
//             first-legal-press lock per player, and a held 5-bit move word.
//  Revision : 1.0  initial release
// ============================================================================
module rps_move_capture #(
    parameter int COUNT_TICKS  = 3,
    parameter int WINDOW_TICKS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] p1_key,
    input  logic [2:0] p2_key,
    input  logic       ack,
    output logic [4:0] move_word,
    output logic       move_valid,
    output logic [3:0] countdown,
    output logic       busy
);

    localparam logic [3:0] c_count_init  = 4'(COUNT_TICKS);
    localparam logic [3:0] c_window_init = 4'(WINDOW_TICKS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_COLLECT   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t     r_state, w_state_n;
    logic [3:0] r_countdown, w_countdown_n;
    logic [3:0] r_window, w_window_n;
    logic       r_p1_lock, w_p1_lock_n;
    logic       r_p2_lock, w_p2_lock_n;
    logic [1:0] r_p1_move, w_p1_move_n;
    logic [1:0] r_p2_move, w_p2_move_n;
    logic [2:0] r_p1_key_q, r_p2_key_q;
    logic [4:0] r_move_word, w_move_word_n;
    logic       r_move_valid, w_move_valid_n;
    logic       r_busy;
    logic [1:0] w_p1_press, w_p2_press;
    logic       w_finish;

    // A rise vector maps to a move only when exactly one key rose.
    function automatic logic [1:0] f_encode(input logic [2:0] rise);
        case (rise)
            3'b001:  return 2'b01;
            3'b010:  return 2'b10;
            3'b100:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    assign w_p1_press = f_encode(p1_key & ~r_p1_key_q);
    assign w_p2_press = f_encode(p2_key & ~r_p2_key_q);

    always_comb begin
        w_state_n      = r_state;
        w_countdown_n  = r_countdown;
        w_window_n     = r_window;
        w_p1_lock_n    = r_p1_lock;
        w_p2_lock_n    = r_p2_lock;
        w_p1_move_n    = r_p1_move;
        w_p2_move_n    = r_p2_move;
        w_move_word_n  = r_move_word;
        w_move_valid_n = r_move_valid;
        w_finish       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n     = S_COUNTDOWN;
                    w_countdown_n = c_count_init;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    if (r_countdown == 4'd1) begin
                        w_state_n     = S_COLLECT;
                        w_countdown_n = 4'd0;
                        w_window_n    = c_window_init;
                    end else begin
                        w_countdown_n = r_countdown - 4'd1;
                    end
                end
            end
            S_COLLECT: begin
                if (!r_p1_lock && (w_p1_press != 2'b00)) begin
                    w_p1_lock_n = 1'b1;
                    w_p1_move_n = w_p1_press;
                end
                if (!r_p2_lock && (w_p2_press != 2'b00)) begin
                    w_p2_lock_n = 1'b1;
                    w_p2_move_n = w_p2_press;
                end
                // A press on the expiry tick is already folded into the moves above.
                if (w_p1_lock_n && w_p2_lock_n) begin
                    w_finish = 1'b1;
                end else if (tick) begin
                    if (r_window == 4'd1) begin
                        w_finish = 1'b1;
                    end else begin
                        w_window_n = r_window - 4'd1;
                    end
                end
                if (w_finish) begin
                    w_state_n      = S_DONE;
                    w_move_word_n  = {1'b1, w_p2_move_n, w_p1_move_n};
                    w_move_valid_n = 1'b1;
                end
            end
            S_DONE: begin
                if (ack) begin
                    w_state_n      = S_IDLE;
                    w_p1_lock_n    = 1'b0;
                    w_p2_lock_n    = 1'b0;
                    w_p1_move_n    = 2'b00;
                    w_p2_move_n    = 2'b00;
                    w_move_word_n  = 5'd0;
                    w_move_valid_n = 1'b0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_countdown  <= 4'd0;
            r_window     <= 4'd0;
            r_p1_lock    <= 1'b0;
            r_p2_lock    <= 1'b0;
            r_p1_move    <= 2'b00;
            r_p2_move    <= 2'b00;
            r_p1_key_q   <= 3'b000;
            r_p2_key_q   <= 3'b000;
            r_move_word  <= 5'd0;
            r_move_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_countdown  <= w_countdown_n;
            r_window     <= w_window_n;
            r_p1_lock    <= w_p1_lock_n;
            r_p2_lock    <= w_p2_lock_n;
            r_p1_move    <= w_p1_move_n;
            r_p2_move    <= w_p2_move_n;
            r_p1_key_q   <= p1_key;
            r_p2_key_q   <= p2_key;
            r_move_word  <= w_move_word_n;
            r_move_valid <= w_move_valid_n;
            r_busy       <= (w_state_n != S_IDLE);
        end
    end

    assign move_word  = r_move_word;
    assign move_valid = r_move_valid;
    assign countdown  = r_countdown;
    assign busy       = r_busy;

endmodule
`default_nettype wire
